// File: rtl/seq_detector_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int unsigned SEQ_MAX_LEN     = 8;
  localparam int unsigned SEQ_COUNT_W     = 8;
  localparam logic [7:0]  SEQ_RST_PATTERN = 8'b0000_0011;
  localparam int unsigned SEQ_RST_LEN     = 3;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a same-cycle increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector: history shift register plus fill count form the state;
// pattern, length and overlap mode are runtime-loadable.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = SEQ_MAX_LEN,
  parameter int unsigned        LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned        COUNT_W     = SEQ_COUNT_W,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(SEQ_RST_PATTERN),
  parameter int unsigned        RST_LEN     = SEQ_RST_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_i,
  input  logic               in_valid_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               clr_count_i,
  output logic               match_o,
  output logic [COUNT_W-1:0] match_count_o
);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift_s, len_mask_s;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc_s;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               match_q;
  logic               accept_s, hit_s;

  // A hit needs len_q fresh bits and the newest len_q history bits equal to the pattern.
  always_comb begin
    accept_s     = in_valid_i & ~cfg_load_i;
    hist_shift_s = {hist_q[MAX_LEN-2:0], in_i};
    if (fill_q >= LEN_W'(MAX_LEN)) begin
      fill_inc_s = fill_q;
    end else begin
      fill_inc_s = fill_q + LEN_W'(1);
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask_s[i] = (i < int'(len_q));
    end
    hit_s = accept_s && (len_q != {LEN_W{1'b0}}) && (fill_inc_s >= len_q) &&
            ((hist_shift_s & len_mask_s) == (pat_q & len_mask_s));
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    if (cfg_load_i) begin
      pat_d  = cfg_pattern_i;
      len_d  = LEN_W'(clamp_len(32'(cfg_len_i), MAX_LEN));
      ovl_d  = cfg_overlap_i;
      hist_d = {MAX_LEN{1'b0}};
      fill_d = {LEN_W{1'b0}};
    end else if (accept_s) begin
      hist_d = hist_shift_s;
      // Non-overlap: the matched bits remain in hist but are no longer counted as fresh.
      if (hit_s && !ovl_q) begin
        fill_d = {LEN_W{1'b0}};
      end else begin
        fill_d = fill_inc_s;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= {MAX_LEN{1'b0}};
      fill_q  <= {LEN_W{1'b0}};
      pat_q   <= RST_PATTERN;
      len_q   <= LEN_W'(clamp_len(RST_LEN, MAX_LEN));
      ovl_q   <= 1'b1;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= hit_s;
    end
  end

  sat_counter #(
    .W(COUNT_W)
  ) u_count (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (hit_s),
    .clr_i   (clr_count_i),
    .count_o (match_count_o)
  );

  assign match_o = match_q;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_seq_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0, in_valid = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b1, clr_count = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       match_a, match_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  // Model: bits accepted since the last reset / load / non-overlap match (newest at back).
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         exp_match;
  int         exp_a, exp_b;

  always #5 clk = ~clk;

  seq_detector u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_i(in_bit), .in_valid_i(in_valid), .cfg_load_i(cfg_load),
    .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap),
    .clr_count_i(clr_count), .match_o(match_a), .match_count_o(cnt_a)
  );

  seq_detector #(.COUNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_i(in_bit), .in_valid_i(in_valid), .cfg_load_i(cfg_load),
    .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap),
    .clr_count_i(clr_count), .match_o(match_b), .match_count_o(cnt_b)
  );

  task automatic reset_model();
    mq.delete();
    m_pat = 8'b0000_0011; m_len = 3; m_ovl = 1'b1;
    exp_match = 1'b0; exp_a = 0; exp_b = 0;
  endtask

  task automatic step(input bit b, input bit v, input bit ld, input bit clr);
    bit hit;
    @(negedge clk);
    in_bit = b; in_valid = v; cfg_load = ld; clr_count = clr;
    hit = 1'b0;
    if (ld) begin
      m_pat = cfg_pattern; m_len = (cfg_len > 4'd8) ? 8 : int'(cfg_len); m_ovl = cfg_overlap;
      mq.delete();
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > 8) void'(mq.pop_front());
      if (m_len > 0 && mq.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++) if (mq[mq.size()-1-i] != m_pat[i]) hit = 1'b0;
      end
      if (hit && !m_ovl) mq.delete();
    end
    exp_match = hit;
    if (clr) begin
      exp_a = 0; exp_b = 0;
    end else if (hit) begin
      if (exp_a < 255) exp_a++;
      if (exp_b < 3) exp_b++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reset_model();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (match_a !== 1'b0 || match_b !== 1'b0 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_err++; $display("FAIL reset: match=%b/%b cnt=%0d/%0d, want all 0", match_a, match_b, cnt_a, cnt_b);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_default_pattern();
    logic [5:0] bits;
    int pulses;
    bits = 6'b011011;
    pulses = 0;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0, 1'b0);
      pulses += int'(match_a);
      n_cmp++;
      if (match_a !== exp_match || match_b !== exp_match || cnt_a !== 8'(exp_a) || cnt_b !== 2'(exp_b)) begin
        n_err++; $display("FAIL default bit%0d: match=%b/%b cnt=%0d/%0d, want %b cnt=%0d/%0d",
                          5-i, match_a, match_b, cnt_a, cnt_b, exp_match, exp_a, exp_b);
      end
    end
    n_cmp++;
    if (pulses != 2 || cnt_a !== 8'd2) begin
      n_err++; $display("FAIL default totals: pulses=%0d cnt=%0d, want 2 and 2", pulses, cnt_a);
    end
  endtask

  task automatic test_overlap_modes();
    int pulses;
    for (int mode = 1; mode >= 0; mode--) begin
      load_cfg(8'h03, 4'd2, 1'(mode));
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
        step(1'b1, 1'b1, 1'b0, 1'b0);
        pulses += int'(match_a);
        n_cmp++;
        if (match_a !== exp_match || match_b !== exp_match || cnt_a !== 8'(exp_a) || cnt_b !== 2'(exp_b)) begin
          n_err++; $display("FAIL overlap%0d bit%0d: match=%b/%b cnt=%0d/%0d, want %b cnt=%0d/%0d",
                            mode, i, match_a, match_b, cnt_a, cnt_b, exp_match, exp_a, exp_b);
        end
      end
      n_cmp++;
      if (pulses != (mode ? 3 : 2) || cnt_a !== (mode ? 8'd3 : 8'd2)) begin
        n_err++; $display("FAIL overlap%0d totals: pulses=%0d cnt=%0d, want %0d", mode, pulses, cnt_a, mode ? 3 : 2);
      end
    end
  endtask

  task automatic test_valid_gaps();
    logic [2:0] bits;
    int pulses;
    bits = 3'b011;
    pulses = 0;
    do_reset();
    for (int i = 2; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0, 1'b0);
      pulses += int'(match_a);
      n_cmp++;
      if (match_a !== exp_match || cnt_a !== 8'(exp_a)) begin
        n_err++; $display("FAIL gaps bit%0d: match=%b cnt=%0d, want %b cnt=%0d", 2-i, match_a, cnt_a, exp_match, exp_a);
      end
      n_cmp++;
      if (match_a !== (i == 0)) begin
        n_err++; $display("FAIL gaps timing bit%0d: match=%b, want %b", 2-i, match_a, i == 0);
      end
      if (i != 0) begin
        repeat (2) begin
          step(1'b1, 1'b0, 1'b0, 1'b0);
          pulses += int'(match_a);
        end
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++; $display("FAIL gaps totals: pulses=%0d, want 1", pulses);
    end
  endtask

  task automatic test_boundary_lengths();
    logic [7:0] stream;
    logic [3:0] lens[3];
    int pulses;
    lens[0] = 4'd8; lens[1] = 4'd9; lens[2] = 4'd0;
    stream = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      load_cfg(8'hA5, lens[k], 1'b1);
      pulses = 0;
      for (int i = 7; i >= 0; i--) begin
        step(stream[i], 1'b1, 1'b0, 1'b0);
        pulses += int'(match_a);
        n_cmp++;
        if (match_a !== exp_match || cnt_a !== 8'(exp_a)) begin
          n_err++; $display("FAIL len%0d bit%0d: match=%b cnt=%0d, want %b cnt=%0d",
                            lens[k], 7-i, match_a, cnt_a, exp_match, exp_a);
        end
      end
      n_cmp++;
      if (pulses != ((k == 2) ? 0 : 1)) begin
        n_err++; $display("FAIL len%0d totals: pulses=%0d, want %0d", lens[k], pulses, (k == 2) ? 0 : 1);
      end
    end
  endtask

  task automatic test_saturation_clear();
    load_cfg(8'h01, 4'd1, 1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (cnt_b !== 2'd3 || cnt_a !== 8'd5 || exp_b != 3) begin
      n_err++; $display("FAIL saturate: cnt=%0d/%0d, want 5/3", cnt_a, cnt_b);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (match_a !== 1'b1 || match_b !== 1'b1 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_err++; $display("FAIL clr_with_match: match=%b/%b cnt=%0d/%0d, want 1 and 0/0", match_a, match_b, cnt_a, cnt_b);
    end
  endtask

  task automatic test_disruption();
    logic [4:0] bits;
    bits = 5'b01101;
    do_reset();
    for (int i = 4; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (match_a !== 1'b0 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_err++; $display("FAIL async_reset: match=%b cnt=%0d/%0d, want 0", match_a, cnt_a, cnt_b);
    end
    reset_model();
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (match_a !== 1'b0 || cnt_a !== 8'd0) begin
      n_err++; $display("FAIL post_reset_1: match=%b cnt=%0d, want 0", match_a, cnt_a);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    load_cfg(8'h03, 4'd3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (match_a !== 1'b0 || match_b !== 1'b0) begin
      n_err++; $display("FAIL load_discard: match=%b/%b, want 0", match_a, match_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        cfg_pattern = 8'($urandom);
        cfg_len = 4'($urandom_range(0, 10));
        if ($urandom_range(0, 3) != 0) cfg_len = 4'($urandom_range(1, 3));
        cfg_overlap = 1'($urandom);
        step(1'b0, 1'($urandom), 1'b1, 1'b0);
      end else begin
        step(1'($urandom), ($urandom_range(0, 9) < 7), 1'b0, ($urandom_range(0, 49) == 0));
      end
      n_cmp++;
      if (match_a !== exp_match || match_b !== exp_match || cnt_a !== 8'(exp_a) || cnt_b !== 2'(exp_b)) begin
        n_err++; $display("FAIL random c%0d: match=%b/%b cnt=%0d/%0d, want %b cnt=%0d/%0d",
                          c, match_a, match_b, cnt_a, cnt_b, exp_match, exp_a, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_overlap_modes();
    test_valid_gaps();
    test_boundary_lengths();
    test_saturation_clear();
    test_disruption();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial bit-pattern detector, the successor to the fixed "011" sequence FSM. It watches a one-bit serial stream qualified by a valid strobe. It flags every occurrence of a runtime-programmable pattern of 1..MAX_LEN bits, in overlapping or non-overlapping mode, and keeps a saturating match count. It sits between a serial front end and control logic that needs framing or marker events.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1): width of the length field.
- COUNT_W, 8: width of the match counter.
- RST_PATTERN, 'b011: pattern loaded at reset (LSB-aligned).
- RST_LEN, 3: pattern length loaded at reset.
- clk  in  1  clock; everything is sampled on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- in  in  1  serial data bit.
- in_valid  in  1  `in` is sampled only when this is high.
- cfg_load  in  1  one-cycle strobe that latches the cfg_* inputs.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr_count  in  1  synchronous clear of match_count.
- match  out  1  one-cycle pulse per detected occurrence.
- match_count  out  COUNT_W  number of matches, saturating.

## Operation
- Held state:
  - history shift register hist[MAX_LEN-1:0].
  - fill counter (0..MAX_LEN): valid bits accepted since the last reset, load or non-overlap match.
  - config registers pat_q, len_q, ovl_q.
- Reset (rst_n=0):
  - hist=0, fill=0, match=0, match_count=0.
  - pat_q=RST_PATTERN, len_q=RST_LEN, ovl_q=1.
- Accept (in_valid=1, cfg_load=0):
  - hist_next = {hist[MAX_LEN-2:0], in}.
  - fill_next = min(fill+1, MAX_LEN).
- Hit condition: fill_next ≥ len_q and hist_next[len_q-1:0] == pat_q[len_q-1:0].
- On a hit:
  - match goes to 1 for one cycle.
  - match_count increments, saturating at 2^COUNT_W-1.
  - If ovl_q=0, fill is forced to 0 (the history bits stay but cannot be reused). If ovl_q=1, fill follows the accept rule.
- No accept (in_valid=0): hist and fill hold; match=0.
- cfg_load=1:
  - Latches pat_q, len_q and ovl_q.
  - Clears hist and fill.
  - in_valid in the same cycle is ignored (no accept, match=0).
  - Does not affect match_count.
- Length rules:
  - cfg_len=0 is stored as 0 and disables detection (match stays 0).
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
- clr_count=1 forces match_count=0 on the next edge. This wins over a simultaneous increment, but match still pulses.

## Timing
- Latency: match is registered. It is high in the cycle after the edge that samples the final pattern bit.
- Back-to-back:
  - Overlap mode can give a match on consecutive accepted bits (for example, pattern "11" on a stream of 1s).
  - Non-overlap mode needs len_q fresh bits between matches.
- Gaps in in_valid stretch the time between matches but do not break a sequence in progress.
- Asynchronous reset mid-stream takes effect immediately on all outputs. The first possible match after reset release needs len_q accepted bits.
- A cfg_load while a sequence is partly received discards that partial sequence. No spurious match may result.

## Structure
- Package seq_det_pkg holds:
  - default parameter constants (MAX_LEN, COUNT_W, RST_PATTERN, RST_LEN).
  - a helper function that clamps the length.
- Sub-module sat_counter (parameter W; ports inc and clr; clr has priority) implements match_count.
- The rest (shift register, fill counter, compare, config registers) lives in the top module. No explicit state-encoded FSM is required: hist together with fill is the state.

## Test plan
- Reset defaults, overlap on, stream 0,1,1,0,1,1 → two match pulses (one cycle after the 3rd and 6th bits); match_count=2.
- cfg_load pattern "11", len 2, overlap=1; stream 1,1,1,1 → matches after bits 2, 3 and 4; count=3. Repeat with overlap=0 → matches after bits 2 and 4 only; count=2.
- in_valid gaps: pattern 011 with two idle cycles between each bit → exactly one match, one cycle after the final valid bit.
- Boundary lengths:
  - cfg_len=MAX_LEN=8, pattern 8'hA5, stream A5 sent MSB first → one match.
  - cfg_len=9 is clamped to 8.
  - cfg_len=0 on any stream → no match.
- Saturation and clear:
  - COUNT_W=2 and 5 matches → match_count holds at 3.
  - clr_count coinciding with a match → count 0, match still pulses.
- Disruption:
  - rst_n pulled low after "01" arrives → outputs 0 immediately; after release a single "1" gives no match.
  - cfg_load after "01" arrives → no match on the next "1".
